// File: rtl/gpr_wb_arbiter_if.sv
// rtl/gpr_wb_arbiter_if.sv - writeback arbiter request/grant/scoreboard bus bundle
interface gpr_wb_arbiter_if;
    logic        p_we;
    logic [4:0]  p_a3;
    logic [31:0] p_wd;
    logic        wb_stall;
    logic        m_valid;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic        m_ready;
    logic        iss_valid;
    logic [4:0]  iss_a3;
    logic        iss_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        hz_stall;
    logic        gpr_we;
    logic [4:0]  gpr_a3;
    logic [31:0] gpr_wd;

    modport master (
        output p_we, p_a3, p_wd, m_valid, m_a3, m_wd, iss_valid, iss_a3, rs1, rs2, rd,
        input  wb_stall, m_ready, iss_ready, hz_stall, gpr_we, gpr_a3, gpr_wd
    );

    modport slave (
        input  p_we, p_a3, p_wd, m_valid, m_a3, m_wd, iss_valid, iss_a3, rs1, rs2, rd,
        output wb_stall, m_ready, iss_ready, hz_stall, gpr_we, gpr_a3, gpr_wd
    );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR write port arbiter between pipeline and mul/div with busy scoreboard
module gpr_wb_arbiter (
    input  logic            clk,
    input  logic            rst,
    gpr_wb_arbiter_if.slave bus
);
    logic        buf_valid_q, buf_valid_d;
    logic [4:0]  buf_a3_q, buf_a3_d;
    logic [31:0] buf_wd_q, buf_wd_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] busy_q, busy_d;

    logic p_live;
    logic buf_grant;
    logic m_accept;
    logic iss_ok;
    logic iss_fire;

    // Arbitration, write-port drive, handshakes and next-state for buffer, age counter and scoreboard
    always_comb begin
        p_live    = bus.p_we && (bus.p_a3 != 5'd0);
        // The buffer wins when the pipeline is idle or after three consecutive denials
        buf_grant = buf_valid_q && (!p_live || (wait_cnt_q == 2'd3));
        m_accept  = bus.m_valid && !buf_valid_q;
        iss_ok    = !busy_q[bus.iss_a3];
        iss_fire  = bus.iss_valid && iss_ok && (bus.iss_a3 != 5'd0);

        bus.m_ready   = !buf_valid_q;
        bus.iss_ready = iss_ok;
        bus.hz_stall  = busy_q[bus.rs1] | busy_q[bus.rs2] | busy_q[bus.rd];

        bus.gpr_we   = 1'b0;
        bus.gpr_a3   = 5'd0;
        bus.gpr_wd   = 32'd0;
        bus.wb_stall = 1'b0;
        if (!rst) begin
            if (buf_grant) begin
                bus.wb_stall = p_live;
                // An entry for x0 is consumed without touching the register file
                if (buf_a3_q != 5'd0) begin
                    bus.gpr_we = 1'b1;
                    bus.gpr_a3 = buf_a3_q;
                    bus.gpr_wd = buf_wd_q;
                end
            end else if (p_live) begin
                bus.gpr_we = 1'b1;
                bus.gpr_a3 = bus.p_a3;
                bus.gpr_wd = bus.p_wd;
            end
        end

        buf_valid_d = buf_valid_q;
        buf_a3_d    = buf_a3_q;
        buf_wd_d    = buf_wd_q;
        // Accept and grant are mutually exclusive because acceptance needs an empty buffer
        if (m_accept) begin
            buf_valid_d = 1'b1;
            buf_a3_d    = bus.m_a3;
            buf_wd_d    = bus.m_wd;
        end else if (buf_grant) begin
            buf_valid_d = 1'b0;
        end

        wait_cnt_d = wait_cnt_q;
        if (!buf_valid_q || buf_grant) begin
            wait_cnt_d = 2'd0;
        end else if (wait_cnt_q != 2'd3) begin
            wait_cnt_d = wait_cnt_q + 2'd1;
        end

        // Clear first so a same-register issue in the same cycle leaves the bit set
        busy_d = busy_q;
        if (buf_grant && (buf_a3_q != 5'd0)) begin
            busy_d[buf_a3_q] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[bus.iss_a3] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset dropping any buffered entry and pending destinations
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_a3_q    <= 5'd0;
            buf_wd_q    <= 32'd0;
            wait_cnt_q  <= 2'd0;
            busy_q      <= 32'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_a3_q    <= buf_a3_d;
            buf_wd_q    <= buf_wd_d;
            wait_cnt_q  <= wait_cnt_d;
            busy_q      <= busy_d;
        end
    end
endmodule
